mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

N-channel SRAM-style request arbiter that merges several CPU-side memory ports (instruction fetch, data access, future DMA/debug masters) onto one shared single-port SRAM with fixed one-cycle read latency. It is the unified-memory front end of the next-generation CPU top level, between the pipeline's SRAM ports and the board memory. It generalises the fixed separate inst/data SRAM pair to a parametrised channel count and bus width. It adds stall back-pressure, round-robin fairness and per-channel held read data.

## Interface
- N_CH, 2: number of requesting channels (1..8); channel 0 is the instruction port by convention.
- ADDR_W, 64: address width.
- DATA_W, 64: data width; byte-enable width BE_W = DATA_W/8.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- ch_en  in  N_CH  per-channel request valid.
- ch_we  in  N_CH*BE_W  per-channel byte write enables; all-zero means read.
- ch_addr  in  N_CH*ADDR_W  per-channel address.
- ch_wdata  in  N_CH*DATA_W  per-channel write data.
- ch_stall  out  N_CH  request not accepted this cycle; master holds all request fields.
- ch_rvalid  out  N_CH  one-cycle pulse: read data for this channel is available.
- ch_rdata  out  N_CH*DATA_W  per-channel held read data.
- mem_en  out  1  shared SRAM enable.
- mem_we  out  BE_W  shared SRAM byte write enables.
- mem_addr  out  ADDR_W  shared SRAM address.
- mem_wdata  out  DATA_W  shared SRAM write data.
- mem_rdata  in  DATA_W  shared SRAM read data, valid the cycle after a read is issued.

Channel i occupies bits [i*W +: W] of each flattened vector.

## Operation
- Each cycle, at most one requesting channel is granted; the grant is combinational from ch_en and the priority pointer.
- Granted channel: its we/addr/wdata drive mem_*, mem_en=1, ch_stall[i]=0.
- Requesting, not granted: ch_stall[i]=1. Not requesting: ch_stall[i]=0.
- No request: mem_en=0, mem_we=0, mem_addr and mem_wdata = 0.
- Round-robin: ptr register (log2 N_CH bits, minimum 1) names the highest-priority channel. Search ascending from ptr with wrap-around. On any grant to channel g, ptr <= (g+1) mod N_CH. With no grant, ptr holds.
- Read response: a granted read (ch_we==0) sets resp_vld<=1 and resp_id<=g. On the next cycle, ch_rdata[resp_id] <= mem_rdata is registered, and ch_rvalid[resp_id] pulses in the same cycle the data is driven.
- Implementation: a combinational bypass drives ch_rdata[resp_id] = mem_rdata while resp_vld. The register captures it, so ch_rdata holds the value until that channel's next read completes.
- Writes complete on grant; no rvalid is produced.
- Back-to-back reads from different channels pipeline at full rate, one per cycle.
- ch_rdata for other channels is never disturbed.
- Requests must not change while stalled. Changing them is a master protocol error, and the arbiter does not check for it.

## Timing
- Grant/stall/mem_* path: zero-cycle combinational from ch_en.
- Read latency: request cycle T accepted, ch_rvalid and ch_rdata valid at T+1.
- Throughput: one access per cycle in aggregate.
- Worst-case wait for a continuously requesting channel: N_CH-1 cycles.
- Reset values: ptr=0, resp_vld=0, resp_id=0, all ch_rdata registers=0, ch_rvalid=0. mem_*/ch_stall follow the combinational rules with the reset state.
- Reset asserted mid-read: the pending response is discarded, and no rvalid is produced after reset release.
- Simultaneous rvalid for channel A and a new grant to channel A: both are legal. The new read's data arrives the following cycle.
- N_CH=1: ptr is constant 0, and the block degenerates to a registered response path.

## Configuration
- MEM_ARB_FIXED_PRIO_EN defined: fixed priority, and the lowest-numbered requesting channel always wins. The ptr register is removed.
- MEM_ARB_FIXED_PRIO_EN not defined (default): round-robin as in Operation.
- All other behaviour is identical in both builds.

## Test plan
- Reset, all ch_en=0 -> mem_en=0, ch_stall=0, ch_rvalid=0, ch_rdata=0. Assert rst mid-read -> no rvalid after release.
- N_CH=2, both channels read continuously (addr 0x100 and 0x200), memory model returns addr+1 -> grants alternate 0,1,0,1. Each rvalid is one cycle after its grant, with rdata 0x101/0x201 held between pulses.
- Channel 1 writes 0xDEADBEEF to 0x40 with we=0xFF while channel 0 is idle -> single-cycle grant, no rvalid, ch_stall[1]=0. A subsequent read of 0x40 returns 0xDEADBEEF.
- N_CH=4, channels 1 and 3 requesting with ptr=2 -> channel 3 granted first, then 1. Stalled channel inputs held -> ch_stall high exactly one cycle.
- Build with MEM_ARB_FIXED_PRIO_EN, channels 0 and 1 requesting continuously -> channel 0 always granted, ch_stall[1]=1 every cycle.
- Read by channel 0 completing in the same cycle as channel 0's next read grant -> rvalid pulses on consecutive cycles with the correct distinct data. ch_rdata[1] is unchanged throughout.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: flattened CPU-side channel signals plus the shared SRAM port.
// The master modport is the requesting side together with the SRAM model; the slave modport is the arbiter.
interface mem_port_arbiter_if #(
   parameter int N_CH   = 2,
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   localparam int BE_W = DATA_W / 8;

   logic [N_CH-1:0]        ch_en;
   logic [N_CH*BE_W-1:0]   ch_we;
   logic [N_CH*ADDR_W-1:0] ch_addr;
   logic [N_CH*DATA_W-1:0] ch_wdata;
   logic [N_CH-1:0]        ch_stall;
   logic [N_CH-1:0]        ch_rvalid;
   logic [N_CH*DATA_W-1:0] ch_rdata;
   logic                   mem_en;
   logic [BE_W-1:0]        mem_we;
   logic [ADDR_W-1:0]      mem_addr;
   logic [DATA_W-1:0]      mem_wdata;
   logic [DATA_W-1:0]      mem_rdata;

   modport master (
      output ch_en, ch_we, ch_addr, ch_wdata, mem_rdata,
      input  ch_stall, ch_rvalid, ch_rdata, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  ch_en, ch_we, ch_addr, ch_wdata, mem_rdata,
      output ch_stall, ch_rvalid, ch_rdata, mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// N-channel arbiter merging memory ports onto one single-port SRAM with one-cycle read latency.
// Round-robin by default; define MEM_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module mem_port_arbiter #(
   parameter int N_CH   = 2,
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);
   localparam int BE_W = DATA_W / 8;
   localparam int ID_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic              gnt_vld;
   logic [ID_W-1:0]   gnt_id;
   logic              resp_vld;
   logic [ID_W-1:0]   resp_id;
   logic [DATA_W-1:0] rdata_q [N_CH];

`ifdef MEM_ARB_FIXED_PRIO_EN
   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (!gnt_vld && bus.ch_en[i]) begin
            gnt_vld = 1'b1;
            gnt_id  = ID_W'(i);
         end
      end
   end
`else
   logic [ID_W-1:0] ptr;

   // Ascending search starting at ptr, wrapping past N_CH-1 back to channel 0.
   always_comb begin
      int unsigned idx;
      gnt_vld = 1'b0;
      gnt_id  = '0;
      idx     = 0;
      for (int unsigned k = 0; k < N_CH; k++) begin
         idx = 32'(ptr) + k;
         if (idx >= N_CH) idx = idx - N_CH;
         if (!gnt_vld && bus.ch_en[idx]) begin
            gnt_vld = 1'b1;
            gnt_id  = ID_W'(idx);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (gnt_vld) begin
         ptr <= (gnt_id == ID_W'(N_CH - 1)) ? '0 : gnt_id + 1'b1;
      end
   end
`endif

   always_comb begin
      bus.mem_en    = gnt_vld;
      bus.mem_we    = '0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.ch_stall  = bus.ch_en;
      if (gnt_vld) begin
         bus.mem_we           = bus.ch_we[gnt_id*BE_W +: BE_W];
         bus.mem_addr         = bus.ch_addr[gnt_id*ADDR_W +: ADDR_W];
         bus.mem_wdata        = bus.ch_wdata[gnt_id*DATA_W +: DATA_W];
         bus.ch_stall[gnt_id] = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_vld <= 1'b0;
         resp_id  <= '0;
         for (int unsigned i = 0; i < N_CH; i++) rdata_q[i] <= '0;
      end else begin
         resp_vld <= gnt_vld && (bus.mem_we == '0);
         if (gnt_vld) resp_id <= gnt_id;
         if (resp_vld) rdata_q[resp_id] <= bus.mem_rdata;
      end
   end

   // Returning read data bypasses the holding register so rvalid and rdata coincide.
   always_comb begin
      bus.ch_rvalid = '0;
      bus.ch_rdata  = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         bus.ch_rvalid[i] = resp_vld && (resp_id == ID_W'(i));
         bus.ch_rdata[i*DATA_W +: DATA_W] = bus.ch_rvalid[i] ? bus.mem_rdata : rdata_q[i];
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a 2-channel and a 4-channel instance driven by directed vectors.
// Expectations follow MEM_ARB_FIXED_PRIO_EN when the bench is built with that macro.
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int unsigned ch;
      logic [63:0] data;
   } resp_t;

   resp_t       q2[$];
   resp_t       q4[$];
   logic [63:0] shadow2 [2];
   logic [63:0] shadow4 [4];

   mem_port_arbiter_if #(.N_CH(2), .ADDR_W(64), .DATA_W(64)) b2 ();
   mem_port_arbiter_if #(.N_CH(4), .ADDR_W(16), .DATA_W(32)) b4 ();

   mem_port_arbiter #(.N_CH(2), .ADDR_W(64), .DATA_W(64)) dut2 (.clk(clk), .rst(rst), .bus(b2));
   mem_port_arbiter #(.N_CH(4), .ADDR_W(16), .DATA_W(32)) dut4 (.clk(clk), .rst(rst), .bus(b4));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // SRAM models: stored data if written, otherwise address+1.
   logic [63:0] mem2 [logic [63:0]];
   always @(posedge clk) begin : sram2
      logic [63:0] w;
      if (b2.mem_en) begin
         if (b2.mem_we != '0) begin
            w = mem2.exists(b2.mem_addr) ? mem2[b2.mem_addr] : 64'h0;
            for (int i = 0; i < 8; i++) if (b2.mem_we[i]) w[i*8 +: 8] = b2.mem_wdata[i*8 +: 8];
            mem2[b2.mem_addr] = w;
         end else begin
            b2.mem_rdata <= mem2.exists(b2.mem_addr) ? mem2[b2.mem_addr] : b2.mem_addr + 64'd1;
         end
      end
   end

   always @(posedge clk) begin
      if (b4.mem_en && b4.mem_we == '0) b4.mem_rdata <= 32'(b4.mem_addr) + 32'd1;
   end

   // Monitors: pop on rvalid, otherwise the channel must keep its last returned data.
   always @(negedge clk) begin
      #1;
      if (rst) begin
         for (int i = 0; i < 2; i++) shadow2[i] = 64'h0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (b2.ch_rvalid[i]) begin
               if (q2.size() == 0) begin
                  check("rvalid2_unexpected", 64'(b2.ch_rvalid), 64'h0);
               end else begin
                  resp_t r;
                  r = q2.pop_front();
                  check("rvalid2_ch", 64'(i), 64'(r.ch));
                  check("rdata2", b2.ch_rdata[i*64 +: 64], r.data);
                  shadow2[i] = r.data;
               end
            end else begin
               check("held2", b2.ch_rdata[i*64 +: 64], shadow2[i]);
            end
         end
      end
   end

   always @(negedge clk) begin
      #1;
      if (rst) begin
         for (int i = 0; i < 4; i++) shadow4[i] = 64'h0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (b4.ch_rvalid[i]) begin
               if (q4.size() == 0) begin
                  check("rvalid4_unexpected", 64'(b4.ch_rvalid), 64'h0);
               end else begin
                  resp_t r;
                  r = q4.pop_front();
                  check("rvalid4_ch", 64'(i), 64'(r.ch));
                  check("rdata4", 64'(b4.ch_rdata[i*32 +: 32]), r.data);
                  shadow4[i] = r.data;
               end
            end else begin
               check("held4", 64'(b4.ch_rdata[i*32 +: 32]), shadow4[i]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int unsigned g;
      b2.ch_en = '0; b2.ch_we = '0; b2.ch_addr = '0; b2.ch_wdata = '0;
      b4.ch_en = '0; b4.ch_we = '0; b4.ch_addr = '0; b4.ch_wdata = '0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_mem_en", 64'(b2.mem_en), 64'h0);
      check("rst_stall", 64'(b2.ch_stall), 64'h0);
      check("rst_rvalid", 64'(b2.ch_rvalid), 64'h0);
      check("rst_rdata0", b2.ch_rdata[63:0], 64'h0);
      check("rst_rdata1", b2.ch_rdata[127:64], 64'h0);
      check("rst_mem_addr", b2.mem_addr, 64'h0);
      check("rst4_rvalid", 64'(b4.ch_rvalid), 64'h0);
      #2 rst = 1'b0;
      tick();

      // Reset asserted while a read is outstanding: response discarded
      b2.ch_en = 2'b01; b2.ch_addr[63:0] = 64'h300;
      @(negedge clk);
      check("rr_mem_en", 64'(b2.mem_en), 64'h1);
      check("rr_mem_addr", b2.mem_addr, 64'h300);
      check("rr_stall", 64'(b2.ch_stall), 64'h0);
      #2 rst = 1'b1; b2.ch_en = 2'b00;
      @(negedge clk);
      check("rr_rvalid_in_rst", 64'(b2.ch_rvalid), 64'h0);
      #2 rst = 1'b0;
      tick();
      @(negedge clk);
      check("rr_rvalid_after", 64'(b2.ch_rvalid), 64'h0);
      tick();

      // Both channels reading continuously
      b2.ch_en = 2'b11; b2.ch_we = '0;
      b2.ch_addr[63:0] = 64'h100; b2.ch_addr[127:64] = 64'h200;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
`ifdef MEM_ARB_FIXED_PRIO_EN
         g = 0;
`else
         g = k % 2;
`endif
         check("both_mem_addr", b2.mem_addr, (g == 1) ? 64'h200 : 64'h100);
         check("both_stall", 64'(b2.ch_stall), (g == 1) ? 64'h1 : 64'h2);
         q2.push_back('{ch: g, data: (g == 1) ? 64'h201 : 64'h101});
         tick();
      end
      b2.ch_en = 2'b00;
      @(negedge clk);
      check("both_idle_mem_en", 64'(b2.mem_en), 64'h0);
      tick();

      // Channel 1 write, then read-back by channel 0
      b2.ch_en = 2'b10; b2.ch_we[15:8] = 8'hFF;
      b2.ch_addr[127:64] = 64'h40; b2.ch_wdata[127:64] = 64'hDEADBEEF;
      @(negedge clk);
      check("wr_mem_en", 64'(b2.mem_en), 64'h1);
      check("wr_mem_we", 64'(b2.mem_we), 64'hFF);
      check("wr_mem_addr", b2.mem_addr, 64'h40);
      check("wr_mem_wdata", b2.mem_wdata, 64'hDEADBEEF);
      check("wr_stall", 64'(b2.ch_stall), 64'h0);
      tick();
      b2.ch_en = 2'b00; b2.ch_we = '0;
      @(negedge clk);
      check("idle_mem_en", 64'(b2.mem_en), 64'h0);
      check("idle_mem_we", 64'(b2.mem_we), 64'h0);
      check("idle_mem_addr", b2.mem_addr, 64'h0);
      check("idle_mem_wdata", b2.mem_wdata, 64'h0);
      tick();
      b2.ch_en = 2'b01; b2.ch_addr[63:0] = 64'h40;
      @(negedge clk);
      check("rb_mem_addr", b2.mem_addr, 64'h40);
      q2.push_back('{ch: 0, data: 64'hDEADBEEF});
      tick();

      // Channel 0 back-to-back: response and new grant share a cycle
      b2.ch_addr[63:0] = 64'h500;
      @(negedge clk);
      check("b2b_mem_addr0", b2.mem_addr, 64'h500);
      q2.push_back('{ch: 0, data: 64'h501});
      tick();
      b2.ch_addr[63:0] = 64'h600;
      @(negedge clk);
      check("b2b_mem_addr1", b2.mem_addr, 64'h600);
      check("b2b_stall", 64'(b2.ch_stall), 64'h0);
      q2.push_back('{ch: 0, data: 64'h601});
      tick();
      b2.ch_en = 2'b00;
      tick();

      // Four channels: move pointer to 2, then channels 1 and 3 compete
      b4.ch_en = 4'b0010; b4.ch_addr[31:16] = 16'h11;
      @(negedge clk);
      check("q4_c1_addr", 64'(b4.mem_addr), 64'h11);
      check("q4_c1_stall", 64'(b4.ch_stall), 64'h0);
      q4.push_back('{ch: 1, data: 64'h12});
      tick();
      b4.ch_en = 4'b1010; b4.ch_addr[31:16] = 16'h21; b4.ch_addr[63:48] = 16'h31;
      @(negedge clk);
`ifdef MEM_ARB_FIXED_PRIO_EN
      check("q4_c2_addr", 64'(b4.mem_addr), 64'h21);
      check("q4_c2_stall", 64'(b4.ch_stall), 64'h8);
      q4.push_back('{ch: 1, data: 64'h22});
      tick();
      b4.ch_en = 4'b1000;
      @(negedge clk);
      check("q4_c3_addr", 64'(b4.mem_addr), 64'h31);
      check("q4_c3_stall", 64'(b4.ch_stall), 64'h0);
      q4.push_back('{ch: 3, data: 64'h32});
`else
      check("q4_c2_addr", 64'(b4.mem_addr), 64'h31);
      check("q4_c2_stall", 64'(b4.ch_stall), 64'h2);
      q4.push_back('{ch: 3, data: 64'h32});
      tick();
      b4.ch_en = 4'b0010;
      @(negedge clk);
      check("q4_c3_addr", 64'(b4.mem_addr), 64'h21);
      check("q4_c3_stall", 64'(b4.ch_stall), 64'h0);
      q4.push_back('{ch: 1, data: 64'h22});
`endif
      tick();
      b4.ch_en = 4'b0000;
      @(negedge clk);
      check("q4_idle_mem_en", 64'(b4.mem_en), 64'h0);
      repeat (3) tick();

      check("q2_drained", 64'(q2.size()), 64'h0);
      check("q4_drained", 64'(q4.size()), 64'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
